// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared UART constants, payload type and pointer-width helper
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int CLK_FREQ    = 50_000_000;
    localparam int BAUDRATE    = 115_200;
    localparam int UART_DATA_W = 8;

    typedef logic [UART_DATA_W-1:0] uart_data_t;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sat_counter.sv
`default_nettype none
// ============================================================================
// uart_sat_counter : up-counter that sticks at all-ones
// Revision : 1.0
// ============================================================================
module uart_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_echo_buffer.sv
`default_nettype none
// ============================================================================
// uart_echo_buffer : single-clock RX-to-TX echo FIFO with overflow policy,
//                    flush and saturating overflow/error counters
// Revision : 1.0
// ============================================================================
module uart_echo_buffer
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_valid,
    input  logic [DATA_W-1:0]      rx_data,
    input  logic                   rx_err,
    output logic                   tx_valid,
    output logic [DATA_W-1:0]      tx_data,
    input  logic                   tx_ready,
    input  logic                   cfg_echo_en,
    input  logic                   cfg_overwrite,
    input  logic                   cfg_flush,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty,
    output logic [CNT_W-1:0]       ovf_count,
    output logic [CNT_W-1:0]       err_count
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;

    logic push;
    logic pop;
    logic wr_en;
    logic ovr_adv;
    logic ovf_inc;
    logic err_inc;

    assign empty    = (head == tail);
    assign full     = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
    assign level    = tail - head;
    assign tx_valid = ~empty;
    assign tx_data  = mem[head[AW-1:0]];

    assign push = rx_valid & ~rx_err & cfg_echo_en;
    assign pop  = tx_valid & tx_ready;

    // A push into a full FIFO only lands if a pop frees the slot or the
    // overwrite policy evicts the oldest entry; flush cancels everything.
    assign wr_en   = push & ~cfg_flush & (~full | pop | cfg_overwrite);
    assign ovr_adv = push & ~cfg_flush & full & ~pop & cfg_overwrite;
    assign ovf_inc = push & ~cfg_flush & full & ~pop;
    assign err_inc = rx_valid & rx_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else if (cfg_flush) begin
            head <= tail;
        end else begin
            if (wr_en) begin
                tail <= tail + 1'b1;
            end
            if (pop || ovr_adv) begin
                head <= head + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[tail[AW-1:0]] <= rx_data;
        end
    end

    uart_sat_counter #(.CNT_W(CNT_W)) u_ovf_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ovf_inc),
        .count (ovf_count)
    );

    uart_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_inc),
        .count (err_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_buffer.sv
`default_nettype none
// ============================================================================
// tb_uart_echo_buffer : directed self-checking bench for uart_echo_buffer
// Revision : 1.0
// ============================================================================
module tb_uart_echo_buffer;

    logic       clk;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_err;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       cfg_echo_en;
    logic       cfg_overwrite;
    logic       cfg_flush;
    logic [4:0] level;
    logic       full;
    logic       empty;
    logic [7:0] ovf_count;
    logic [7:0] err_count;

    int checks   = 0;
    int failures = 0;

    uart_echo_buffer #(.DATA_W(8), .DEPTH(16), .CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_err        (rx_err),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .cfg_echo_en   (cfg_echo_en),
        .cfg_overwrite (cfg_overwrite),
        .cfg_flush     (cfg_flush),
        .level         (level),
        .full          (full),
        .empty         (empty),
        .ovf_count     (ovf_count),
        .err_count     (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        rx_valid      = 1'b0;
        rx_data       = 8'h00;
        rx_err        = 1'b0;
        tx_ready      = 1'b0;
        cfg_echo_en   = 1'b1;
        cfg_overwrite = 1'b0;
        cfg_flush     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push_byte(input logic [7:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_ovf", 32'(ovf_count), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);

        // ---------------- test 1: basic echo ----------------
        push_byte(8'h41);
        chk("t1_latency_valid", 32'(tx_valid), 32'd1);
        push_byte(8'h42);
        push_byte(8'h43);
        chk("t1_level3", 32'(level), 32'd3);
        chk("t1_head41", 32'(tx_data), 32'h41);
        tx_ready = 1'b1;
        chk("t1_out41", 32'(tx_data), 32'h41);
        tick();
        chk("t1_out42", 32'(tx_data), 32'h42);
        tick();
        chk("t1_out43", 32'(tx_data), 32'h43);
        tick();
        chk("t1_empty", 32'(empty), 32'd1);
        tx_ready = 1'b0;

        // ---------------- test 2: drop-new overflow ----------------
        do_reset();
        for (int i = 0; i < 17; i++) push_byte(8'(i));
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_level", 32'(level), 32'd16);
        chk("t2_ovf", 32'(ovf_count), 32'd1);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t2_drain%0d", i), 32'(tx_data), 32'(i));
            tick();
        end
        chk("t2_empty", 32'(empty), 32'd1);
        tx_ready = 1'b0;

        // ---------------- test 3: overwrite-oldest overflow ----------------
        do_reset();
        cfg_overwrite = 1'b1;
        for (int i = 0; i < 18; i++) push_byte(8'(i));
        chk("t3_ovf", 32'(ovf_count), 32'd2);
        chk("t3_level", 32'(level), 32'd16);
        tx_ready = 1'b1;
        for (int i = 2; i < 18; i++) begin
            chk($sformatf("t3_drain%0d", i), 32'(tx_data), 32'(i));
            tick();
        end
        chk("t3_empty", 32'(empty), 32'd1);
        tx_ready      = 1'b0;
        cfg_overwrite = 1'b0;

        // ---------------- test 4: full, push and pop together ----------------
        do_reset();
        for (int i = 0; i < 16; i++) push_byte(8'hA0 + 8'(i));
        chk("t4_full_before", 32'(full), 32'd1);
        tx_ready = 1'b1;
        push_byte(8'h55);
        tx_ready = 1'b0;
        chk("t4_level", 32'(level), 32'd16);
        chk("t4_ovf", 32'(ovf_count), 32'd0);
        tx_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("t4_drain%0d", i), 32'(tx_data), 32'hA0 + 32'(i));
            tick();
        end
        chk("t4_last55", 32'(tx_data), 32'h55);
        tick();
        chk("t4_empty", 32'(empty), 32'd1);
        tx_ready = 1'b0;

        // ---------------- test 5: error frames and echo disable ----------------
        do_reset();
        rx_err = 1'b1;
        push_byte(8'h7E);
        rx_err = 1'b0;
        chk("t5_err1", 32'(err_count), 32'd1);
        chk("t5_level0", 32'(level), 32'd0);
        cfg_echo_en = 1'b0;
        push_byte(8'h33);
        chk("t5_noecho_level", 32'(level), 32'd0);
        chk("t5_noecho_empty", 32'(empty), 32'd1);
        cfg_echo_en = 1'b1;
        rx_err   = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h7E;
        for (int i = 0; i < 300; i++) tick();
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        chk("t5_err_sat", 32'(err_count), 32'd255);
        chk("t5_ovf_zero", 32'(ovf_count), 32'd0);
        chk("t5_level_end", 32'(level), 32'd0);

        // ---------------- test 6: flush and asynchronous reset ----------------
        do_reset();
        for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
        chk("t6_level5", 32'(level), 32'd5);
        cfg_flush = 1'b1;
        tx_ready  = 1'b1;
        push_byte(8'h99);
        cfg_flush = 1'b0;
        tx_ready  = 1'b0;
        chk("t6_flush_level", 32'(level), 32'd0);
        chk("t6_flush_valid", 32'(tx_valid), 32'd0);
        chk("t6_flush_ovf", 32'(ovf_count), 32'd0);
        rx_err = 1'b1;
        push_byte(8'hEE);
        rx_err = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(8'h20 + 8'(i));
        chk("t6_level4", 32'(level), 32'd4);
        chk("t6_err_pre", 32'(err_count), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_level", 32'(level), 32'd0);
        chk("t6_async_empty", 32'(empty), 32'd1);
        chk("t6_async_valid", 32'(tx_valid), 32'd0);
        chk("t6_async_err", 32'(err_count), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_after_rst_empty", 32'(empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
